load_store_unit: RTL and testbench
==================================

# load_store_unit

Pipeline-side initiator for the data port of the MMU. Accepts one load or store at a time from the execute stage over a valid/ready handshake, drives the MMU data-port signals (address, write data, read/write enables), honours the MMU wait and segfault indications, and returns a result over a second valid/ready handshake. Sub-word stores are performed as read-modify-write, because the MMU data port is word-granular.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  request present
- op_ready  out  1  unit can accept a request
- op_store  in  1  1 = store, 0 = load
- op_size  in  2  00 word, 01 halfword, 10 byte, 11 reserved
- op_signed  in  1  sign-extend sub-word loads
- op_lane  in  2  byte lane within the addressed word
- op_addr  in  32  word address presented to the MMU
- op_wdata  in  32  store data, right-aligned
- res_valid  out  1  result present
- res_ready  in  1  consumer takes the result
- res_data  out  32  load data, right-aligned and extended; 0 for stores and faults
- res_fault  out  1  request faulted
- res_cause  out  2  0 none, 1 segv, 2 misaligned, 3 illegal size
- mem_addr  out  32  to MMU data_addr
- mem_wdata  out  32  to MMU data_in
- mem_rd  out  1  to MMU rd
- mem_wd  out  1  to MMU wd
- mem_rdata  in  32  from MMU data; registered by the MMU, valid the cycle after an accepted read
- mem_wait  in  1  from MMU wait_data
- mem_segv  in  1  from MMU data_segv; combinational in mem_addr

## Operation
States: IDLE, ISSUE, CAPTURE, WRITE, DONE.
- IDLE: op_ready=1. On op_valid, latch all op_* fields and go to ISSUE. A misaligned request (halfword with op_lane[0]=1) or an illegal size goes straight to DONE with the matching cause, and no MMU access is made.
- ISSUE: mem_addr is the latched address. mem_rd=1 for loads and sub-word stores. mem_wd=1 with mem_wdata=op_wdata for word stores.
  - mem_segv=1: go to DONE with cause 1. This check takes priority over mem_wait.
  - mem_wait=1: stay in ISSUE and hold all signals.
  - Otherwise: a word store goes to DONE; every other request goes to CAPTURE.
- CAPTURE: sample mem_rdata.
  - Loads: select the lane (byte lanes 0-3; halfword lanes 0 and 2), zero- or sign-extend according to op_signed, then go to DONE.
  - Sub-word stores: merge op_wdata into the selected lane of mem_rdata, leaving the other bytes unchanged, then go to WRITE.
- WRITE: mem_wd=1 with the merged word. mem_wait stalls here as in ISSUE. mem_segv=1 gives cause 1. Then go to DONE.
- DONE: res_valid=1 with res_data, res_fault and res_cause stable. On res_ready go to IDLE. There is no bypass: a new op is accepted at the earliest one cycle later.
- Byte lane n maps to bits [8n+7:8n].
- mem_rd and mem_wd are never both 1. Both are 0 in every state except ISSUE and WRITE.

## Timing
- Reset values: state IDLE, op_ready=1, res_valid=0, res_data=0, res_fault=0, res_cause=0, mem_addr=0, mem_wdata=0, mem_rd=0, mem_wd=0.
- A reset in any state aborts the operation. No further enables are driven and the result is discarded.
- Latency from the accept cycle T to the first res_valid, with no waits:
  - word load: T+3
  - word store: T+2
  - sub-word store: T+4
  - pre-check fault: T+1
- Each cycle of mem_wait=1 in ISSUE or WRITE adds exactly one cycle.
- A held result blocks new requests: op_ready=0 until the cycle after the res_valid and res_ready handshake.

## Configuration
- LSU_SUBWORD_EN defined: halfword and byte sizes, lane selection, sign extension and read-modify-write (the WRITE state) are all present.
- LSU_SUBWORD_EN undefined: only word size is legal. Sizes 01, 10 and 11 fault with cause 3 and no MMU access. op_lane and op_signed are ignored. The WRITE state and the merge logic are removed.

## Test plan
- Word load from 0x20, MMU returns 0xDEADBEEF, no waits: mem_rd pulses for one cycle, then res_valid at T+3 with res_data=0xDEADBEEF and res_cause=0.
- Signed byte load, lane 3, mem_rdata=0x80123456: res_data=0xFFFFFF80. The same load unsigned gives 0x00000080.
- Byte store of 0xAB, lane 1, to a word holding 0x11223344: a read, then mem_wd with mem_wdata=0x1122AB44; res_valid at T+4.
- Word store with mem_wait held high for 3 cycles: mem_wd and mem_addr stay stable for 4 cycles, and res_valid arrives at T+5.
- Load from address 0 (mem_segv=1): res_fault=1, res_cause=1, res_data=0, and no CAPTURE cycle. Separately, a halfword at lane 1 gives cause 2 at T+1 with mem_rd never asserted.
- rst asserted while in CAPTURE during a sub-word store: no mem_wd follows, and the next cycle shows op_ready=1 and res_valid=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store initiator for the MMU data port: one op at a time, sub-word stores done as read-modify-write.
// Define LSU_SUBWORD_EN to build halfword/byte support; without it only word accesses are legal.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_store,
    input  logic [1:0]  op_size,
    input  logic        op_signed,
    input  logic [1:0]  op_lane,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_fault,
    output logic [1:0]  res_cause,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wd,
    input  logic [31:0] mem_rdata,
    input  logic        mem_wait,
    input  logic        mem_segv
);

`ifdef LSU_SUBWORD_EN
    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, WRITE, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
`endif

    state_t     state;
    logic [1:0] pre_cause;
    logic       word_store;

`ifdef LSU_SUBWORD_EN
    logic       st_store;
    logic [1:0] st_size;
    logic [1:0] st_lane;
    logic       st_signed;

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (size)
            2'b01:   return {{16{sgn & h[15]}}, h};
            2'b10:   return {{24{sgn & b[7]}}, b};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] r;
        r = old;
        if (size == 2'b01) begin
            if (lane[1]) r[31:16] = wd[15:0];
            else         r[15:0]  = wd[15:0];
        end else begin
            r[{lane, 3'b000} +: 8] = wd[7:0];
        end
        return r;
    endfunction

    assign word_store = op_store && (op_size == 2'b00);
`else
    logic unused_subword;
    assign unused_subword = ^{op_lane, op_signed};
    assign word_store     = op_store;
`endif

    // Requests that can never reach the MMU are rejected before any access.
    always_comb begin
        pre_cause = 2'd0;
`ifdef LSU_SUBWORD_EN
        if (op_size == 2'b11)                 pre_cause = 2'd3;
        else if (op_size == 2'b01 && op_lane[0]) pre_cause = 2'd2;
`else
        if (op_size != 2'b00)                 pre_cause = 2'd3;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_ready  <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= 32'd0;
            res_fault <= 1'b0;
            res_cause <= 2'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_rd    <= 1'b0;
            mem_wd    <= 1'b0;
`ifdef LSU_SUBWORD_EN
            st_store  <= 1'b0;
            st_size   <= 2'd0;
            st_lane   <= 2'd0;
            st_signed <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        op_ready  <= 1'b0;
                        mem_addr  <= op_addr;
                        mem_wdata <= op_wdata;
                        res_data  <= 32'd0;
                        res_fault <= 1'b0;
                        res_cause <= 2'd0;
`ifdef LSU_SUBWORD_EN
                        st_store  <= op_store;
                        st_size   <= op_size;
                        st_lane   <= op_lane;
                        st_signed <= op_signed;
`endif
                        if (pre_cause != 2'd0) begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                            res_fault <= 1'b1;
                            res_cause <= pre_cause;
                        end else begin
                            state  <= ISSUE;
                            mem_wd <= word_store;
                            mem_rd <= !word_store;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_segv) begin
                        mem_rd    <= 1'b0;
                        mem_wd    <= 1'b0;
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_fault <= 1'b1;
                        res_cause <= 2'd1;
                    end else if (!mem_wait) begin
                        mem_rd <= 1'b0;
                        mem_wd <= 1'b0;
                        // mem_wd in ISSUE only ever marks a word store, which needs no read.
                        if (mem_wd) begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                        end else begin
                            state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
`ifdef LSU_SUBWORD_EN
                    if (st_store) begin
                        mem_wdata <= store_merge(mem_rdata, mem_wdata, st_size, st_lane);
                        mem_wd    <= 1'b1;
                        state     <= WRITE;
                    end else begin
                        res_data  <= load_extract(mem_rdata, st_size, st_lane, st_signed);
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
`else
                    res_data  <= mem_rdata;
                    res_valid <= 1'b1;
                    state     <= DONE;
`endif
                end
`ifdef LSU_SUBWORD_EN
                WRITE: begin
                    if (mem_segv) begin
                        mem_wd    <= 1'b0;
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_fault <= 1'b1;
                        res_cause <= 2'd1;
                    end else if (!mem_wait) begin
                        mem_wd    <= 1'b0;
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small MMU model (registered read data, address-0 segfault).
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, op_ready, op_store, op_signed;
    logic [1:0]  op_size, op_lane;
    logic [31:0] op_addr, op_wdata;
    logic        res_valid, res_ready, res_fault;
    logic [31:0] res_data;
    logic [1:0]  res_cause;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wd, mem_wait, mem_segv;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd_word;
    int          waits_left;
    int          lat, n_rd, n_wd;
    logic [31:0] wd_dat;
    logic        addr_bad, both_bad;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_store(op_store), .op_size(op_size),
        .op_signed(op_signed), .op_lane(op_lane), .op_addr(op_addr), .op_wdata(op_wdata),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_fault(res_fault), .res_cause(res_cause),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wd(mem_wd),
        .mem_rdata(mem_rdata), .mem_wait(mem_wait), .mem_segv(mem_segv)
    );

    always #5 clk = ~clk;

    assign mem_segv = (mem_addr < 32'h10);

    always @(posedge clk) begin
        if (mem_rd && !mem_wait && !mem_segv) mem_rdata <= rd_word;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, then follow it cycle by cycle until res_valid, logging MMU activity.
    task automatic run_op(input logic st, input logic [1:0] sz, input logic sg, input logic [1:0] ln,
                          input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] word,
                          input int waits);
        op_store = st; op_size = sz; op_signed = sg; op_lane = ln;
        op_addr = ad; op_wdata = wd; rd_word = word; waits_left = waits;
        mem_wait = 1'b0;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        lat = 1; n_rd = 0; n_wd = 0; wd_dat = 32'd0; addr_bad = 1'b0; both_bad = 1'b0;
        for (int i = 0; i < 40 && !res_valid; i++) begin
            mem_wait = (waits_left > 0) && (mem_rd || mem_wd);
            if (mem_wait) waits_left--;
            if (mem_rd) n_rd++;
            if (mem_wd) begin
                n_wd++;
                wd_dat = mem_wdata;
            end
            if ((mem_rd || mem_wd) && mem_addr !== ad) addr_bad = 1'b1;
            if (mem_rd && mem_wd) both_bad = 1'b1;
            tick();
            lat++;
        end
        mem_wait = 1'b0;
    endtask

    task automatic finish_op(input string tag);
        check({tag, "_busy"}, {31'd0, op_ready}, 32'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_rdy"}, {31'd0, op_ready}, 32'd1);
        check({tag, "_vld_clr"}, {31'd0, res_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_store = 1'b0; op_size = 2'd0; op_signed = 1'b0;
        op_lane = 2'd0; op_addr = 32'd0; op_wdata = 32'd0; res_ready = 1'b0;
        mem_wait = 1'b0; rd_word = 32'd0; waits_left = 0;
        tick(); tick();
        check("rst_op_ready", {31'd0, op_ready}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_mem_en", {30'd0, mem_rd, mem_wd}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_res", {res_data[29:0], res_fault, res_cause[0]} | {31'd0, res_cause[1]}, 32'd0);
        rst = 1'b0;
        tick();

        // word load, no waits
        run_op(1'b0, 2'b00, 1'b0, 2'd0, 32'h20, 32'h0, 32'hDEADBEEF, 0);
        check("wl_lat", lat, 3);
        check("wl_nrd", n_rd, 1);
        check("wl_nwd", n_wd, 0);
        check("wl_data", res_data, 32'hDEADBEEF);
        check("wl_cause", {res_fault, res_cause}, 3'b000);
        // result held while consumer stalls
        tick();
        check("wl_hold_vld", {31'd0, res_valid}, 32'd1);
        check("wl_hold_data", res_data, 32'hDEADBEEF);
        finish_op("wl");

        // word store, no waits
        run_op(1'b1, 2'b00, 1'b0, 2'd0, 32'h40, 32'h12345678, 32'h0, 0);
        check("ws_lat", lat, 2);
        check("ws_nrd", n_rd, 0);
        check("ws_nwd", n_wd, 1);
        check("ws_wdata", wd_dat, 32'h12345678);
        check("ws_res", {res_data[30:0], res_fault}, 32'd0);
        finish_op("ws");

        // word store, three wait cycles
        run_op(1'b1, 2'b00, 1'b0, 2'd0, 32'h44, 32'hCAFEF00D, 32'h0, 3);
        check("wsw_lat", lat, 5);
        check("wsw_nwd", n_wd, 4);
        check("wsw_addr_stable", {31'd0, addr_bad}, 32'd0);
        check("wsw_wdata", wd_dat, 32'hCAFEF00D);
        finish_op("wsw");

        // word load, two wait cycles
        run_op(1'b0, 2'b00, 1'b0, 2'd0, 32'h80, 32'h0, 32'h0BADF00D, 2);
        check("wlw_lat", lat, 5);
        check("wlw_nrd", n_rd, 3);
        check("wlw_data", res_data, 32'h0BADF00D);
        finish_op("wlw");

        // load from address 0 segfaults with no CAPTURE cycle
        run_op(1'b0, 2'b00, 1'b0, 2'd0, 32'h0, 32'h0, 32'h55555555, 0);
        check("segv_lat", lat, 2);
        check("segv_fault", {res_fault, res_cause}, 3'b101);
        check("segv_data", res_data, 32'd0);
        finish_op("segv");

`ifdef LSU_SUBWORD_EN
        run_op(1'b0, 2'b10, 1'b1, 2'd3, 32'h100, 32'h0, 32'h80123456, 0);
        check("lbs_lat", lat, 3);
        check("lbs_data", res_data, 32'hFFFFFF80);
        finish_op("lbs");
        run_op(1'b0, 2'b10, 1'b0, 2'd3, 32'h100, 32'h0, 32'h80123456, 0);
        check("lbu_data", res_data, 32'h00000080);
        finish_op("lbu");
        run_op(1'b0, 2'b01, 1'b1, 2'd2, 32'h104, 32'h0, 32'h80011234, 0);
        check("lhs_data", res_data, 32'hFFFF8001);
        finish_op("lhs");
        run_op(1'b0, 2'b01, 1'b1, 2'd0, 32'h104, 32'h0, 32'h80011234, 0);
        check("lh0_data", res_data, 32'h00001234);
        finish_op("lh0");

        run_op(1'b1, 2'b10, 1'b0, 2'd1, 32'h200, 32'h000000AB, 32'h11223344, 0);
        check("sb_lat", lat, 4);
        check("sb_nrd", n_rd, 1);
        check("sb_nwd", n_wd, 1);
        check("sb_merge", wd_dat, 32'h1122AB44);
        check("sb_both", {31'd0, both_bad}, 32'd0);
        check("sb_res", {res_data[30:0], res_fault}, 32'd0);
        finish_op("sb");
        run_op(1'b1, 2'b01, 1'b0, 2'd2, 32'h204, 32'h9999BEEF, 32'h11223344, 1);
        check("sh_lat", lat, 5);
        check("sh_merge", wd_dat, 32'hBEEF3344);
        finish_op("sh");

        run_op(1'b0, 2'b01, 1'b0, 2'd1, 32'h300, 32'h0, 32'h0, 0);
        check("mis_lat", lat, 1);
        check("mis_nrd", n_rd, 0);
        check("mis_cause", {res_fault, res_cause}, 3'b110);
        finish_op("mis");
        run_op(1'b0, 2'b11, 1'b0, 2'd0, 32'h300, 32'h0, 32'h0, 0);
        check("ill_lat", lat, 1);
        check("ill_cause", {res_fault, res_cause}, 3'b111);
        finish_op("ill");
`else
        run_op(1'b0, 2'b10, 1'b1, 2'd3, 32'h100, 32'h0, 32'h80123456, 0);
        check("byte_lat", lat, 1);
        check("byte_nrd", n_rd, 0);
        check("byte_cause", {res_fault, res_cause}, 3'b111);
        check("byte_data", res_data, 32'd0);
        finish_op("byte");
        run_op(1'b1, 2'b01, 1'b0, 2'd1, 32'h100, 32'hAB, 32'h0, 0);
        check("half_cause", {res_fault, res_cause}, 3'b111);
        check("half_nwd", n_wd + n_rd, 0);
        finish_op("half");
        run_op(1'b0, 2'b11, 1'b0, 2'd0, 32'h100, 32'h0, 32'h0, 0);
        check("rsv_cause", {res_fault, res_cause}, 3'b111);
        finish_op("rsv");
`endif

        // reset while in CAPTURE aborts the op
`ifdef LSU_SUBWORD_EN
        op_store = 1'b1; op_size = 2'b10; op_lane = 2'd1;
`else
        op_store = 1'b0; op_size = 2'b00; op_lane = 2'd0;
`endif
        op_signed = 1'b0; op_addr = 32'h400; op_wdata = 32'hAB; rd_word = 32'h11223344;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        check("rc_issue_rd", {31'd0, mem_rd}, 32'd1);
        tick();
        check("rc_capture_en", {30'd0, mem_rd, mem_wd}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rc_op_ready", {31'd0, op_ready}, 32'd1);
        check("rc_res_valid", {31'd0, res_valid}, 32'd0);
        n_wd = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_wd || mem_rd || res_valid) n_wd++;
            tick();
        end
        check("rc_quiet", n_wd, 0);

        // unit is usable again after the abort
        run_op(1'b0, 2'b00, 1'b0, 2'd0, 32'h24, 32'h0, 32'h76543210, 0);
        check("post_lat", lat, 3);
        check("post_data", res_data, 32'h76543210);
        finish_op("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
